// File: rtl/arb_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
// Port ids tag in-flight reads; MAX_LATENCY bounds the tag pipe.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DRAIN
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MAX_LATENCY = 8;

endpackage

// File: rtl/arb_tag_pipe.sv
// {valid, port} shift register that follows each read to its return.
// Head entry lines up with mem_rdata; async clear drops in-flight reads.
module arb_tag_pipe
  import arb_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_port,
  output logic head_valid,
  output logic head_port,
  output logic empty
);

  localparam int DEPTH =
    (LATENCY < 1) ? 1 :
    (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] prt;

  // Advance every cycle; idle and write cycles shift in an invalid slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      prt <= '0;
    end else begin
      vld[0] <= in_valid;
      prt[0] <= in_port;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        prt[i] <= prt[i-1];
      end
    end
  end

  assign head_valid = vld[DEPTH-1];
  assign head_port  = prt[DEPTH-1];
  assign empty      = ~|vld;

endmodule

// File: rtl/mem_arbiter.sv
// I-cache / D-cache arbiter in front of a fixed-latency main memory.
// Define ARB_RR_EN for round-robin tie-break; default is D priority.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_data,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_data,
  output logic              d_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  logic   issue_rd;
  logic   issue_port;
  logic   head_valid;
  logic   head_port;
  logic   pipe_empty;

`ifdef ARB_RR_EN
  logic   last_srv;
`endif

  // Grant the owning port and steer its access onto the memory bus
  always_comb begin
    i_gnt      = (state == GNT_I) & i_req;
    d_gnt      = (state == GNT_D) & d_req;
    mem_en     = i_gnt | d_gnt;
    mem_wr     = d_gnt & d_wr;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
    issue_rd   = mem_en & ~mem_wr;
    issue_port = d_gnt ? PORT_D : PORT_I;
  end

  // Ownership FSM; DRAIN waits out in-flight reads before re-arbitrating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef ARB_RR_EN
      last_srv <= PORT_I;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (d_req & i_req) begin
`ifdef ARB_RR_EN
            if (last_srv == PORT_I) begin
              state    <= GNT_D;
              last_srv <= PORT_D;
            end else begin
              state    <= GNT_I;
              last_srv <= PORT_I;
            end
`else
            state <= GNT_D;
`endif
          end else if (d_req) begin
            state <= GNT_D;
          end else if (i_req) begin
            state <= GNT_I;
          end
        end
        GNT_I: if (!i_req) state <= DRAIN;
        GNT_D: if (!d_req) state <= DRAIN;
        DRAIN: if (pipe_empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  arb_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_rd),
    .in_port   (issue_port),
    .head_valid(head_valid),
    .head_port (head_port),
    .empty     (pipe_empty)
  );

  assign i_data       = mem_rdata;
  assign d_data       = mem_rdata;
  assign i_data_valid = head_valid & (head_port == PORT_I);
  assign d_data_valid = head_valid & (head_port == PORT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at LATENCY 4 and LATENCY 1.
// Both instances share stimulus; each has its own memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic        d_wr = 1'b0;
  logic [15:0] d_wdata = '0;

  logic        i_gnt4, i_dv4, d_gnt4, d_dv4, mem_en4, mem_wr4;
  logic [15:0] i_data4, d_data4, mem_addr4, mem_wdata4, mem_rdata4;
  logic        i_gnt1, i_dv1, d_gnt1, d_dv1, mem_en1, mem_wr1;
  logic [15:0] i_data1, d_data1, mem_addr1, mem_wdata1, mem_rdata1;

  logic [15:0] q4 [4];
  logic [15:0] q1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(4), .ADDR_W(16), .DATA_W(16)) u4 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt4),
    .i_data(i_data4), .i_data_valid(i_dv4),
    .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_gnt(d_gnt4), .d_data(d_data4), .d_data_valid(d_dv4),
    .mem_en(mem_en4), .mem_wr(mem_wr4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  mem_arbiter #(.LATENCY(1), .ADDR_W(16), .DATA_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1),
    .i_data(i_data1), .i_data_valid(i_dv1),
    .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_data(d_data1), .d_data_valid(d_dv1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // Memory returns ~address, LATENCY cycles after the issue
  always @(posedge clk) begin
    q4[0] <= mem_addr4;
    for (int i = 1; i < 4; i++) q4[i] <= q4[i-1];
    q1 <= mem_addr1;
  end

  assign mem_rdata4 = ~q4[3];
  assign mem_rdata1 = ~q1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    for (int k = 0; k < n; k++) nxt();
  endtask

  // Winner reads 2 words and drops; loser waits, then reads 2 words
  task automatic tie_round(input bit d_first, input string nm);
    logic wg, lg, wdv, ldv;
    for (int t = 0; t <= 16; t++) begin
      nxt();
      d_wr   = 1'b0;
      d_addr = 16'h2000 + 16'(2 * t);
      i_addr = 16'h3000 + 16'(2 * t);
      d_req  = d_first ? (t <= 2) : (t <= 10);
      i_req  = d_first ? (t <= 10) : (t <= 2);
      #1;
      wg  = d_first ? d_gnt4 : i_gnt4;
      lg  = d_first ? i_gnt4 : d_gnt4;
      wdv = d_first ? d_dv4 : i_dv4;
      ldv = d_first ? i_dv4 : d_dv4;
      chk1($sformatf("%s win_gnt t=%0d", nm, t), wg, t >= 1 && t <= 2);
      chk1($sformatf("%s lose_gnt t=%0d", nm, t), lg, t >= 9 && t <= 10);
      chk1($sformatf("%s win_dv t=%0d", nm, t), wdv, t >= 5 && t <= 6);
      chk1($sformatf("%s lose_dv t=%0d", nm, t), ldv, t >= 13 && t <= 14);
      chk1($sformatf("%s overlap t=%0d", nm, t),
           (i_gnt4 & d_dv4) | (d_gnt4 & i_dv4), 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk1("rst i_gnt", i_gnt4, 1'b0);
    chk1("rst d_gnt", d_gnt4, 1'b0);
    chk1("rst mem_en", mem_en4, 1'b0);
    chk1("rst mem_wr", mem_wr4, 1'b0);
    chk16("rst mem_addr", mem_addr4, 16'h0000);
    chk16("rst mem_wdata", mem_wdata4, 16'h0000);
    chk1("rst i_dv", i_dv4, 1'b0);
    chk1("rst d_dv", d_dv4, 1'b0);
    nxt();
    nxt();
    rst_n = 1'b1;
    idle(2);

    // Single 8-word I fill
    nxt();
    i_req  = 1'b1;
    i_addr = 16'h1230;
    #1;
    chk1("fill gnt t=0", i_gnt4, 1'b0);
    for (int t = 1; t <= 14; t++) begin
      nxt();
      i_req  = (t <= 8);
      i_addr = (t <= 8) ? 16'h1230 + 16'(2 * (t - 1)) : 16'h1230;
      #1;
      chk1($sformatf("fill i_gnt t=%0d", t), i_gnt4, t <= 8);
      chk16($sformatf("fill mem_addr t=%0d", t), mem_addr4,
            (t <= 8) ? 16'h1230 + 16'(2 * (t - 1)) : 16'h0000);
      chk1($sformatf("fill i_dv t=%0d", t), i_dv4, t >= 5 && t <= 12);
      chk1($sformatf("fill d_dv t=%0d", t), d_dv4, 1'b0);
      chk1($sformatf("fill l1 i_dv t=%0d", t), i_dv1, t >= 2 && t <= 9);
      if (t >= 5 && t <= 12)
        chk16($sformatf("fill i_data t=%0d", t), i_data4,
              ~(16'h1230 + 16'(2 * (t - 5))));
    end
    idle(2);

    // Two simultaneous-request rounds
    tie_round(1'b1, "tie1");
`ifdef ARB_RR_EN
    tie_round(1'b0, "tie2");
`else
    tie_round(1'b1, "tie2");
`endif
    idle(10);

    // D write-through store
    for (int t = 0; t <= 7; t++) begin
      nxt();
      d_req   = (t <= 1);
      d_wr    = (t <= 1);
      d_addr  = 16'h0400;
      d_wdata = 16'hBEEF;
      #1;
      chk1($sformatf("wr mem_en t=%0d", t), mem_en4, t == 1);
      chk1($sformatf("wr mem_wr t=%0d", t), mem_wr4, t == 1);
      chk16($sformatf("wr addr t=%0d", t), mem_addr4,
            (t == 1) ? 16'h0400 : 16'h0000);
      chk16($sformatf("wr wdata t=%0d", t), mem_wdata4,
            (t == 1) ? 16'hBEEF : 16'h0000);
      chk1($sformatf("wr d_dv t=%0d", t), d_dv4, 1'b0);
      chk1($sformatf("wr i_dv t=%0d", t), i_dv4, 1'b0);
    end
    idle(10);

    // Reset pulse two cycles after a read issue
    for (int t = 0; t <= 9; t++) begin
      nxt();
      d_wr   = 1'b0;
      d_addr = 16'h0500;
      d_req  = (t <= 3);
      if (t == 3) rst_n = 1'b0;
      if (t == 4) rst_n = 1'b1;
      #1;
      chk1($sformatf("rstmid d_gnt t=%0d", t), d_gnt4, t == 1 || t == 2);
      chk1($sformatf("rstmid mem_en t=%0d", t), mem_en4, t == 1 || t == 2);
      chk16($sformatf("rstmid addr t=%0d", t), mem_addr4,
            (t == 1 || t == 2) ? 16'h0500 : 16'h0000);
      chk1($sformatf("rstmid d_dv t=%0d", t), d_dv4, 1'b0);
      chk1($sformatf("rstmid i_dv t=%0d", t), i_dv4, 1'b0);
      chk1($sformatf("rstmid l1 d_dv t=%0d", t), d_dv1, t == 2);
    end
    idle(10);

    // LATENCY 1: alternating single reads
    for (int r = 0; r < 4; r++) begin
      bit is_d;
      is_d = (r % 2 == 0);
      for (int t = 0; t <= 4; t++) begin
        nxt();
        d_wr   = 1'b0;
        d_addr = 16'h0600 + 16'(r);
        i_addr = 16'h0700 + 16'(r);
        d_req  = is_d && (t <= 1);
        i_req  = !is_d && (t <= 1);
        #1;
        chk1($sformatf("alt%0d d_gnt t=%0d", r, t), d_gnt1, is_d && t == 1);
        chk1($sformatf("alt%0d i_gnt t=%0d", r, t), i_gnt1, !is_d && t == 1);
        chk1($sformatf("alt%0d d_dv t=%0d", r, t), d_dv1, is_d && t == 2);
        chk1($sformatf("alt%0d i_dv t=%0d", r, t), i_dv1, !is_d && t == 2);
        if (t == 2)
          chk16($sformatf("alt%0d data", r), is_d ? d_data1 : i_data1,
                is_d ? ~(16'h0600 + 16'(r)) : ~(16'h0700 + 16'(r)));
      end
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
